// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the connection-box configuration loader.
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_e;

    // Config bits for one connection box: mux select width per io times ios.
    function automatic int cb_cfg_bits(input int width, input int ios);
        return $clog2(width + 2) * ios;
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in/serial-out slice register: presents one bit per advance, MSB first,
// and flags when the index has reached bit 0.
module cfg_piso #(
    parameter  int W  = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] din,
    output logic         bit_out,
    output logic         last
);

    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          bit_q, bit_d;
    logic [IW-1:0] idx_next;

    assign idx_next = idx_q - IW'(1);

    // The presented bit is a flop so it holds steady whenever shifting pauses.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        bit_d  = bit_q;
        if (load) begin
            data_d = din;
            idx_d  = IW'(W - 1);
            bit_d  = din[W-1];
        end else if (advance) begin
            idx_d = idx_next;
            bit_d = data_q[idx_next];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_q <= '0;
            idx_q  <= '0;
            bit_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            bit_q  <= bit_d;
        end
    end

    assign bit_out = bit_q;
    assign last    = (idx_q == '0);

endmodule

// File: rtl/cfg_chain_loader.sv
// Host-word to dual config-chain serializer; keeps the fabric in config mode
// until a full chain load completes and accumulates tail readback parity.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter  int CHAIN_LEN = 120,
    parameter  int SLICE_W   = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 word_valid,
    input  logic [2*SLICE_W-1:0] word_data,
    output logic                 word_ready,
    input  logic                 chain_tailA,
    input  logic                 chain_tailB,
    output logic                 cfg_data_A,
    output logic                 cfg_data_B,
    output logic                 cfg_shift,
    output logic                 cfg_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     bit_count,
    output logic                 rb_parityA,
    output logic                 rb_parityB
);

    // Host handshake: a word transfers on a cycle where word_valid and
    // word_ready are both high; word_ready depends only on state.

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             par_a_q, par_a_d;
    logic             par_b_q, par_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_en_q, cfg_en_d;
    logic             cfg_shift_q, cfg_shift_d;

    logic             slice_load;
    logic             slice_advance;
    logic             last_a, last_b;
    logic             last_bit;

    assign last_bit = (bit_count_q == CNT_W'(CHAIN_LEN - 1));

    // Outputs are computed from the next state so cfg_shift is high exactly
    // during SHIFT cycles; the chain and the parity both sample on that edge.
    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        par_a_d       = par_a_q;
        par_b_d       = par_b_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cfg_en_d      = cfg_en_q;
        cfg_shift_d   = 1'b0;
        slice_load    = 1'b0;
        slice_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_FETCH;
                    bit_count_d = '0;
                    par_a_d     = 1'b0;
                    par_b_d     = 1'b0;
                    busy_d      = 1'b1;
                    cfg_en_d    = 1'b1;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (word_valid) begin
                    slice_load  = 1'b1;
                    state_d     = ST_SHIFT;
                    cfg_shift_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    bit_count_d = bit_count_q + CNT_W'(1);
                    par_a_d     = par_a_q ^ chain_tailA;
                    par_b_d     = par_b_q ^ chain_tailB;
                    if (last_bit) begin
                        // Remaining low bits of a partial final word are dropped.
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        cfg_en_d = 1'b0;
                    end else if (last_a && last_b) begin
                        state_d = ST_FETCH;
                    end else begin
                        slice_advance = 1'b1;
                        cfg_shift_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            bit_count_q <= '0;
            par_a_q     <= 1'b0;
            par_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_en_q    <= 1'b1;
            cfg_shift_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            par_a_q     <= par_a_d;
            par_b_q     <= par_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_en_q    <= cfg_en_d;
            cfg_shift_q <= cfg_shift_d;
        end
    end

    cfg_piso #(.W(SLICE_W)) u_piso_a (
        .clk     (clk),
        .nrst    (nrst),
        .load    (slice_load),
        .advance (slice_advance),
        .din     (word_data[SLICE_W-1:0]),
        .bit_out (cfg_data_A),
        .last    (last_a)
    );

    cfg_piso #(.W(SLICE_W)) u_piso_b (
        .clk     (clk),
        .nrst    (nrst),
        .load    (slice_load),
        .advance (slice_advance),
        .din     (word_data[2*SLICE_W-1:SLICE_W]),
        .bit_out (cfg_data_B),
        .last    (last_b)
    );

    assign word_ready = (state_q == ST_FETCH);
    assign cfg_shift  = cfg_shift_q;
    assign cfg_en     = cfg_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bit_count  = bit_count_q;
    assign rb_parityA = par_a_q;
    assign rb_parityB = par_b_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a long (120-bit) and a short (30-bit) instance,
// each driving behavioural chains whose tails feed back into the loader.
module tb_cfg_chain_loader;

    localparam int SW    = 8;
    localparam int LEN_L = 120;
    localparam int LEN_S = 30;
    localparam int CW_L  = $clog2(LEN_L + 1);
    localparam int CW_S  = $clog2(LEN_S + 1);

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic start_l = 1'b0, start_s = 1'b0, abort = 1'b0, word_valid = 1'b0;
    logic [2*SW-1:0] word_data = '0;

    logic l_ready, l_da, l_db, l_shift, l_en, l_busy, l_done, l_pa, l_pb;
    logic [CW_L-1:0] l_cnt;
    logic s_ready, s_da, s_db, s_shift, s_en, s_busy, s_done, s_pa, s_pb;
    logic [CW_S-1:0] s_cnt;

    logic [LEN_L-1:0] ch_la, ch_lb;
    logic [LEN_S-1:0] ch_sa, ch_sb;
    logic preload_req = 1'b1;

    always #5 clk = ~clk;

    cfg_chain_loader #(.CHAIN_LEN(LEN_L), .SLICE_W(SW)) u_dut_l (
        .clk(clk), .nrst(nrst), .start(start_l), .abort(abort),
        .word_valid(word_valid), .word_data(word_data), .word_ready(l_ready),
        .chain_tailA(ch_la[LEN_L-1]), .chain_tailB(ch_lb[LEN_L-1]),
        .cfg_data_A(l_da), .cfg_data_B(l_db), .cfg_shift(l_shift), .cfg_en(l_en),
        .busy(l_busy), .done(l_done), .bit_count(l_cnt),
        .rb_parityA(l_pa), .rb_parityB(l_pb)
    );

    cfg_chain_loader #(.CHAIN_LEN(LEN_S), .SLICE_W(SW)) u_dut_s (
        .clk(clk), .nrst(nrst), .start(start_s), .abort(abort),
        .word_valid(word_valid), .word_data(word_data), .word_ready(s_ready),
        .chain_tailA(ch_sa[LEN_S-1]), .chain_tailB(ch_sb[LEN_S-1]),
        .cfg_data_A(s_da), .cfg_data_B(s_db), .cfg_shift(s_shift), .cfg_en(s_en),
        .busy(s_busy), .done(s_done), .bit_count(s_cnt),
        .rb_parityA(s_pa), .rb_parityB(s_pb)
    );

    // Behavioural chains: shift in at bit 0 on every enabled edge.
    always @(posedge clk) begin
        if (preload_req) begin
            ch_la <= '1; ch_lb <= '1; ch_sa <= '1; ch_sb <= '1;
        end else begin
            if (l_shift) begin
                ch_la <= {ch_la[LEN_L-2:0], l_da};
                ch_lb <= {ch_lb[LEN_L-2:0], l_db};
            end
            if (s_shift) begin
                ch_sa <= {ch_sa[LEN_S-2:0], s_da};
                ch_sb <= {ch_sb[LEN_S-2:0], s_db};
            end
        end
    end

    int sel = 0;
    logic o_ready, o_shift, o_en, o_busy, o_done, o_pa, o_pb;
    int o_cnt;
    always_comb begin
        if (sel == 0) begin
            o_ready = l_ready; o_shift = l_shift; o_en = l_en; o_busy = l_busy;
            o_done = l_done; o_pa = l_pa; o_pb = l_pb; o_cnt = int'(l_cnt);
        end else begin
            o_ready = s_ready; o_shift = s_shift; o_en = s_en; o_busy = s_busy;
            o_done = s_done; o_pa = s_pa; o_pb = s_pb; o_cnt = int'(s_cnt);
        end
    end

    int shift_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (o_shift === 1'b1) shift_cnt++;
        if (o_done === 1'b1) done_cnt++;
    end

    int errors = 0;
    int checks = 0;
    logic [2*SW-1:0] words_q[$];
    logic [0:0] exp_a_q[$];
    logic [0:0] exp_b_q[$];
    logic pre_par_a[2];
    logic pre_par_b[2];
    int base_shift, base_done;

    function automatic int cur_len();
        return (sel == 0) ? LEN_L : LEN_S;
    endfunction

    // Expected chain stream: each word MSB first, cut off at the chain length.
    task automatic build_expect(input int len);
        exp_a_q.delete();
        exp_b_q.delete();
        foreach (words_q[w]) begin
            for (int b = SW - 1; b >= 0; b--) begin
                if (exp_a_q.size() < len) begin
                    exp_a_q.push_back(words_q[w][b]);
                    exp_b_q.push_back(words_q[w][SW + b]);
                end
            end
        end
    endtask

    task automatic preload_chains();
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        pre_par_a[0] = 1'(LEN_L % 2); pre_par_b[0] = 1'(LEN_L % 2);
        pre_par_a[1] = 1'(LEN_S % 2); pre_par_b[1] = 1'(LEN_S % 2);
    endtask

    task automatic random_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(16'($urandom_range(0, 65535)));
    endtask

    task automatic run_load(input int gap_word, input int gap_len, input int abort_at,
                            output bit aborted);
        int wi = 0;
        int cyc = 0;
        int bad;
        bit gap_done;
        bit accepted;
        aborted = 1'b0;
        gap_done = (gap_word < 0);
        base_shift = shift_cnt;
        base_done = done_cnt;
        @(negedge clk);
        if (sel == 0) start_l = 1'b1; else start_s = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        start_s = 1'b0;
        while (wi < words_q.size() && cyc < 3000) begin
            if (abort_at >= 0 && o_cnt == abort_at) begin
                abort = 1'b1;
                word_valid = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (wi == gap_word && !gap_done) begin
                word_valid = 1'b0;
                if (o_ready === 1'b1) begin
                    bad = 0;
                    for (int g = 0; g < gap_len; g++) begin
                        if (o_shift !== 1'b0 || o_ready !== 1'b1) bad++;
                        @(negedge clk);
                        cyc++;
                    end
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL backpressure_gap: violating cycles=%0d required=0", bad);
                    end
                    gap_done = 1'b1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
                continue;
            end
            word_valid = 1'b1;
            word_data = words_q[wi];
            accepted = (o_ready === 1'b1);
            @(negedge clk);
            cyc++;
            if (accepted) wi++;
        end
        word_valid = 1'b0;
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL load_feed_timeout: words accepted=%0d required=%0d", wi, words_q.size());
        end
    endtask

    task automatic check_load(input string name);
        int len = cur_len();
        int waited = 0;
        int bad_a = 0;
        int bad_b = 0;
        logic xa, xb;
        while (o_done !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b required=1", name, o_done);
            return;
        end
        checks++;
        if (o_busy !== 1'b0 || o_en !== 1'b0 || o_shift !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_flags: busy=%b cfg_en=%b cfg_shift=%b required=0,0,0",
                     name, o_busy, o_en, o_shift);
        end
        checks++;
        if (o_cnt != len) begin
            errors++;
            $display("FAIL %s_bit_count: got=%0d required=%0d", name, o_cnt, len);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || done_cnt - base_done != 1) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b pulses=%0d required=0,1",
                     name, o_done, done_cnt - base_done);
        end
        checks++;
        if (shift_cnt - base_shift != len) begin
            errors++;
            $display("FAIL %s_shift_count: got=%0d required=%0d", name, shift_cnt - base_shift, len);
        end
        build_expect(len);
        for (int k = 0; k < len; k++) begin
            if (sel == 0) begin
                if (ch_la[len-1-k] !== exp_a_q[k][0]) bad_a++;
                if (ch_lb[len-1-k] !== exp_b_q[k][0]) bad_b++;
            end else begin
                if (ch_sa[len-1-k] !== exp_a_q[k][0]) bad_a++;
                if (ch_sb[len-1-k] !== exp_b_q[k][0]) bad_b++;
            end
        end
        checks++;
        if (bad_a != 0 || bad_b != 0) begin
            errors++;
            $display("FAIL %s_chain_image: wrong bits A=%0d B=%0d required=0,0", name, bad_a, bad_b);
        end
        checks++;
        if (o_pa !== pre_par_a[sel] || o_pb !== pre_par_b[sel]) begin
            errors++;
            $display("FAIL %s_parity: got A=%b B=%b required A=%b B=%b",
                     name, o_pa, o_pb, pre_par_a[sel], pre_par_b[sel]);
        end
        xa = 1'b0;
        xb = 1'b0;
        for (int k = 0; k < len; k++) begin
            xa ^= exp_a_q[k][0];
            xb ^= exp_b_q[k][0];
        end
        pre_par_a[sel] = xa;
        pre_par_b[sel] = xb;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (l_en !== 1'b1 || s_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_en: got=%b/%b required=1", l_en, s_en);
        end
        checks++;
        if (l_shift !== 1'b0 || l_busy !== 1'b0 || l_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: shift=%b busy=%b done=%b required=0", l_shift, l_busy, l_done);
        end
        checks++;
        if (l_ready !== 1'b0 || l_cnt !== '0) begin
            errors++;
            $display("FAIL reset_ready_count: ready=%b count=%0d required=0,0", l_ready, l_cnt);
        end
        checks++;
        if (l_pa !== 1'b0 || l_pb !== 1'b0 || l_da !== 1'b0 || l_db !== 1'b0) begin
            errors++;
            $display("FAIL reset_data_parity: da=%b db=%b pa=%b pb=%b required=0",
                     l_da, l_db, l_pa, l_pb);
        end
        nrst = 1'b1;
        preload_chains();
    endtask

    task automatic test_full_load();
        bit ab;
        sel = 0;
        preload_chains();
        words_q.delete();
        for (int i = 0; i < LEN_L / SW; i++) words_q.push_back(16'h3CA5);
        run_load(-1, 0, -1, ab);
        check_load("full_load");
    endtask

    task automatic test_partial_word();
        bit ab;
        sel = 1;
        preload_chains();
        random_words(4);
        run_load(-1, 0, -1, ab);
        check_load("partial_word");
        sel = 0;
    endtask

    task automatic test_backpressure();
        bit ab;
        sel = 0;
        preload_chains();
        random_words(LEN_L / SW);
        run_load(7, 5, -1, ab);
        check_load("backpressure");
    endtask

    task automatic test_back_to_back();
        bit ab;
        sel = 0;
        for (int r = 0; r < 2; r++) begin
            random_words(LEN_L / SW);
            run_load(-1, 0, -1, ab);
            check_load("back_to_back");
        end
    endtask

    task automatic test_abort();
        bit ab;
        sel = 0;
        preload_chains();
        random_words(LEN_L / SW);
        run_load(-1, 0, 37, ab);
        checks++;
        if (!ab) begin
            errors++;
            $display("FAIL abort_reach: bit_count 37 not reached, last=%0d", o_cnt);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_en !== 1'b1 || o_cnt != 37) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b cfg_en=%b count=%0d required 0,0,1,37",
                     o_busy, o_done, o_en, o_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_shift !== 1'b0 || o_cnt != 37 || done_cnt != base_done) begin
            errors++;
            $display("FAIL abort_frozen: shift=%b count=%0d dones=%0d required 0,37,0",
                     o_shift, o_cnt, done_cnt - base_done);
        end
        preload_chains();
        random_words(LEN_L / SW);
        run_load(-1, 0, -1, ab);
        check_load("after_abort");
    endtask

    task automatic test_abort_start_idle();
        sel = 0;
        @(negedge clk);
        abort = 1'b1;
        start_l = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start_l = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0 || o_en !== 1'b0 || o_cnt != LEN_L) begin
            errors++;
            $display("FAIL abort_start_idle: busy=%b ready=%b cfg_en=%b count=%0d required 0,0,0,%0d",
                     o_busy, o_ready, o_en, o_cnt, LEN_L);
        end
    endtask

    task automatic test_async_reset();
        bit ab;
        sel = 0;
        random_words(3);
        run_load(-1, 0, -1, ab);
        repeat (3) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (o_en !== 1'b1 || o_busy !== 1'b0 || o_shift !== 1'b0 || o_cnt != 0 || o_pa !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cfg_en=%b busy=%b shift=%b count=%0d pa=%b required 1,0,0,0,0",
                     o_en, o_busy, o_shift, o_cnt, o_pa);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2;
        test_reset();
        test_full_load();
        test_partial_word();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_abort_start_idle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
